// File: rtl/pmod_bus_pkg.sv
// rtl/pmod_bus_pkg.sv - shared types and constants for the PMOD bus bridge
//
// Purpose: FSM state encoding, address field positions and the fixed read
//          data returned for timed-out and unmapped accesses.
// Ports:   none (package).
package pmod_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam int SLOT_LSB = 8;
   localparam int SLOT_MSB = 11;
   localparam int WIN_LSB  = 12;

   localparam logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF;
   localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

endpackage

// File: rtl/pmod_bus_watchdog.sv
// rtl/pmod_bus_watchdog.sv - access timeout counter for the PMOD bus bridge
//
// Purpose: counts cycles spent waiting on a slot and flags the last allowed
//          cycle so the bridge can force a completion.
// Ports:   clk, resetn - clock, synchronous active-low reset
//          clr         - reset the count to zero (takes priority over en)
//          en          - advance the count by one
//          expire      - count has reached TIMEOUT_CYCLES-1
module pmod_bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic expire
);

   // One spare bit so the count can never wrap before expire is acted on.
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pmod_bus_bridge.sv
// rtl/pmod_bus_bridge.sv - CPU memory bus to per-slot PMOD control bridge
//
// Purpose: decodes a 4 KB window into 256-byte slots, turns each hit into a
//          held ctrl_wr/ctrl_rd strobe, and completes the CPU access on the
//          slot's ctrl_done or on a watchdog timeout.
// Ports:   clk, resetn                    - clock, synchronous active-low reset
//          mem_valid/addr/wdata/wstrb     - CPU request (wstrb==0 means read)
//          mem_ready/mem_rdata            - one-cycle completion and read data
//          ctrl_wr/ctrl_rd                - per-slot one-hot strobes
//          ctrl_addr/ctrl_wdat            - shared register offset and data
//          ctrl_rdat/ctrl_done            - per-slot read data and completion
//          err_timeout                    - sticky timeout flag
module pmod_bus_bridge
   import pmod_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
   parameter int          NUM_SLOTS      = 4,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   mem_valid,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_wstrb,
   output logic                   mem_ready,
   output logic [31:0]            mem_rdata,
   output logic [NUM_SLOTS-1:0]   ctrl_wr,
   output logic [NUM_SLOTS-1:0]   ctrl_rd,
   output logic [7:0]             ctrl_addr,
   output logic [31:0]            ctrl_wdat,
   input  logic [32*NUM_SLOTS-1:0] ctrl_rdat,
   input  logic [NUM_SLOTS-1:0]   ctrl_done,
   output logic                   err_timeout
);

   state_e                 state_q, state_d;
   logic [3:0]             slot_q, slot_d;
   logic                   mem_ready_q, mem_ready_d;
   logic [31:0]            mem_rdata_q, mem_rdata_d;
   logic [NUM_SLOTS-1:0]   ctrl_wr_q, ctrl_wr_d;
   logic [NUM_SLOTS-1:0]   ctrl_rd_q, ctrl_rd_d;
   logic [7:0]             ctrl_addr_q, ctrl_addr_d;
   logic [31:0]            ctrl_wdat_q, ctrl_wdat_d;
   logic                   err_timeout_q, err_timeout_d;

   logic                   hit;
   logic [3:0]             req_slot;
   logic                   req_mapped;
   logic [NUM_SLOTS-1:0]   req_oh;
   logic                   done_sel;
   logic [31:0]            rdat_sel;
   logic                   wd_clr, wd_en, wd_expire;

   assign hit        = mem_valid && (mem_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
   assign req_slot   = mem_addr[SLOT_MSB:SLOT_LSB];
   assign req_mapped = ({1'b0, req_slot} < 5'(NUM_SLOTS));

   // Only the selected slot's done/rdata matter; other slots are ignored.
   always_comb begin
      req_oh   = '0;
      done_sel = 1'b0;
      rdat_sel = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         req_oh[i] = (req_slot == 4'(i));
         if (slot_q == 4'(i)) begin
            done_sel = ctrl_done[i];
            rdat_sel = ctrl_rdat[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      mem_ready_d   = 1'b0;
      mem_rdata_d   = mem_rdata_q;
      ctrl_wr_d     = ctrl_wr_q;
      ctrl_rd_d     = ctrl_rd_q;
      ctrl_addr_d   = ctrl_addr_q;
      ctrl_wdat_d   = ctrl_wdat_q;
      err_timeout_d = err_timeout_q;
      wd_clr        = 1'b0;
      wd_en         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (hit && !mem_ready_q) begin
               if (req_mapped) begin
                  slot_d      = req_slot;
                  ctrl_addr_d = mem_addr[SLOT_LSB-1:0];
                  ctrl_wdat_d = mem_wdata;
                  if (mem_wstrb != 4'b0000) begin
                     ctrl_wr_d = req_oh;
                  end else begin
                     ctrl_rd_d = req_oh;
                  end
                  wd_clr  = 1'b1;
                  state_d = ST_ACCESS;
               end else begin
                  mem_rdata_d = UNMAPPED_RDATA;
                  mem_ready_d = 1'b1;
                  state_d     = ST_RESP;
               end
            end
         end
         ST_ACCESS: begin
            wd_en = 1'b1;
            // done is checked first so a late reply beats the watchdog.
            if (done_sel) begin
               ctrl_wr_d   = '0;
               ctrl_rd_d   = '0;
               mem_rdata_d = rdat_sel;
               mem_ready_d = 1'b1;
               state_d     = ST_RESP;
            end else if (wd_expire) begin
               ctrl_wr_d     = '0;
               ctrl_rd_d     = '0;
               mem_rdata_d   = TIMEOUT_RDATA;
               mem_ready_d   = 1'b1;
               err_timeout_d = 1'b1;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         slot_q        <= '0;
         mem_ready_q   <= 1'b0;
         mem_rdata_q   <= '0;
         ctrl_wr_q     <= '0;
         ctrl_rd_q     <= '0;
         ctrl_addr_q   <= '0;
         ctrl_wdat_q   <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         mem_ready_q   <= mem_ready_d;
         mem_rdata_q   <= mem_rdata_d;
         ctrl_wr_q     <= ctrl_wr_d;
         ctrl_rd_q     <= ctrl_rd_d;
         ctrl_addr_q   <= ctrl_addr_d;
         ctrl_wdat_q   <= ctrl_wdat_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   pmod_bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   assign mem_ready   = mem_ready_q;
   assign mem_rdata   = mem_rdata_q;
   assign ctrl_wr     = ctrl_wr_q;
   assign ctrl_rd     = ctrl_rd_q;
   assign ctrl_addr   = ctrl_addr_q;
   assign ctrl_wdat   = ctrl_wdat_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_pmod_bus_bridge.sv
// tb/tb_pmod_bus_bridge.sv - scoreboard testbench for pmod_bus_bridge
module tb_pmod_bus_bridge;

   localparam logic [31:0] BASE = 32'h0300_0000;

   typedef struct {
      logic        chk;
      logic [31:0] rdata;
   } exp_t;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         mem_valid = 1'b0;
   logic [31:0]  mem_addr = '0;
   logic [31:0]  mem_wdata = '0;
   logic [3:0]   mem_wstrb = '0;
   logic         mem_ready;
   logic [31:0]  mem_rdata;
   logic [3:0]   ctrl_wr, ctrl_rd;
   logic [7:0]   ctrl_addr;
   logic [31:0]  ctrl_wdat;
   logic [127:0] ctrl_rdat = '0;
   logic [3:0]   ctrl_done = '0;
   logic         err_timeout;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   ready_seen = 0;
   int   ready_want = 0;

   always #5 clk = ~clk;

   pmod_bus_bridge #(
      .BASE_ADDR      (BASE),
      .NUM_SLOTS      (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .ctrl_wr     (ctrl_wr),
      .ctrl_rd     (ctrl_rd),
      .ctrl_addr   (ctrl_addr),
      .ctrl_wdat   (ctrl_wdat),
      .ctrl_rdat   (ctrl_rdat),
      .ctrl_done   (ctrl_done),
      .err_timeout (err_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Monitor: every mem_ready pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (resetn && mem_ready) begin
         ready_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) check("mem_rdata", mem_rdata, e.rdata);
         end
      end
   end

   task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      mem_valid = 1'b1;
   endtask

   task automatic push_exp(input logic chk, input logic [31:0] rdata);
      exp_t e;
      e.chk = chk;
      e.rdata = rdata;
      exp_q.push_back(e);
      ready_want++;
   endtask

   // Mapped access; the slot raises done d cycles after the strobe appears.
   task automatic slot_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int slot, input int d,
                              input logic [31:0] rdat, input logic [3:0] exp_wr,
                              input logic [3:0] exp_rd, input logic [7:0] exp_addr);
      int hi;
      push_exp(wstrb == 4'b0000, rdat);
      issue(addr, wdata, wstrb);
      @(posedge clk); #1;
      check({tag, "_ctrl_addr"}, 32'(ctrl_addr), 32'(exp_addr));
      if (wstrb != 4'b0000) check({tag, "_ctrl_wdat"}, ctrl_wdat, wdata);
      hi = 0;
      for (int k = 0; k < d; k++) begin
         if (ctrl_wr == exp_wr && ctrl_rd == exp_rd) hi++;
         @(posedge clk); #1;
      end
      ctrl_done[slot] = 1'b1;
      ctrl_rdat[32*slot +: 32] = rdat;
      @(negedge clk);
      if (ctrl_wr == exp_wr && ctrl_rd == exp_rd) hi++;
      check({tag, "_strobe_cycles"}, 32'(hi), 32'(d + 1));
      @(posedge clk); #1;
      ctrl_done = '0;
      check({tag, "_strobe_drop"}, {24'd0, ctrl_wr, ctrl_rd}, 32'd0);
      check({tag, "_ready"}, 32'(mem_ready), 32'd1);
      mem_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_ready_pulse"}, 32'(mem_ready), 32'd0);
   endtask

   initial begin
      int hi, rdy;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(mem_ready), 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_strobes", {24'd0, ctrl_wr, ctrl_rd}, 32'd0);
      check("rst_addr_wdat", {24'd0, ctrl_addr} | ctrl_wdat, 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      slot_access("wr_slot1", BASE + 32'h104, 32'h0000_00A5, 4'b1111, 1, 2, 32'h0, 4'b0010, 4'b0000, 8'h04);
      slot_access("rd_slot2", BASE + 32'h208, 32'h0, 4'b0000, 2, 3, 32'h1234_5678, 4'b0000, 4'b0100, 8'h08);
      slot_access("wr_part3", BASE + 32'h3FC, 32'hDEAD_BEEF, 4'b0100, 3, 1, 32'h0, 4'b1000, 4'b0000, 8'hFC);
      slot_access("rd_slot0", BASE + 32'h010, 32'h0, 4'b0000, 0, 1, 32'hA5A5_0F0F, 4'b0000, 4'b0001, 8'h10);

      // Unmapped slot 15: immediate response with zero data, no strobe.
      push_exp(1'b1, 32'h0);
      issue(BASE + 32'hF00, 32'h0, 4'b0000);
      @(posedge clk); #1;
      check("unmapped_strobe", {24'd0, ctrl_wr, ctrl_rd}, 32'd0);
      check("unmapped_ready", 32'(mem_ready), 32'd1);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      check("unmapped_ready_pulse", 32'(mem_ready), 32'd0);
      @(posedge clk); #1;

      // Outside the window: never answered, never strobed.
      issue(BASE + 32'h1000, 32'h0, 4'b0000);
      hi = 0;
      rdy = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if (ctrl_wr != 4'b0 || ctrl_rd != 4'b0) hi++;
         if (mem_ready) rdy++;
      end
      mem_valid = 1'b0;
      check("miss_strobe_cycles", 32'(hi), 32'd0);
      check("miss_ready_cycles", 32'(rdy), 32'd0);
      @(posedge clk); #1;

      // Slot 0 never answers: strobe for 16 cycles, then forced completion.
      push_exp(1'b1, 32'hFFFF_FFFF);
      issue(BASE + 32'h020, 32'h0, 4'b0000);
      hi = 0;
      rdy = 0;
      for (int k = 0; k < 40 && rdy == 0; k++) begin
         @(posedge clk); #1;
         if (ctrl_rd == 4'b0001) hi++;
         if (mem_ready) rdy = 1;
         else check("to_err_early", 32'(err_timeout), 32'd0);
      end
      mem_valid = 1'b0;
      check("to_completed", 32'(rdy), 32'd1);
      check("to_strobe_cycles", 32'(hi), 32'd16);
      check("to_err", 32'(err_timeout), 32'd1);
      @(posedge clk); #1;

      slot_access("rd_after_to", BASE + 32'h3C0, 32'h0, 4'b0000, 3, 2, 32'h0BAD_CAFE, 4'b0000, 4'b1000, 8'hC0);
      check("err_sticky", 32'(err_timeout), 32'd1);

      // Reset while a slot access is outstanding.
      issue(BASE + 32'h200, 32'h0, 4'b0000);
      @(posedge clk); #1;
      check("pre_rst_strobe", 32'(ctrl_rd), 32'(4'b0100));
      resetn = 1'b0;
      mem_valid = 1'b0;
      @(posedge clk); #1;
      check("midrst_strobes", {24'd0, ctrl_wr, ctrl_rd}, 32'd0);
      check("midrst_ready", 32'(mem_ready), 32'd0);
      check("midrst_err", 32'(err_timeout), 32'd0);
      check("midrst_regs", mem_rdata | ctrl_wdat | {24'd0, ctrl_addr}, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;
      slot_access("rd_post_rst", BASE + 32'h344, 32'h0, 4'b0000, 3, 1, 32'hCAFE_F00D, 4'b0000, 4'b1000, 8'h44);
      check("post_rst_err", 32'(err_timeout), 32'd0);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("ready_count", 32'(ready_seen), 32'(ready_want));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
